mo_mem_responder: RTL

//  Memory-side responder for the matrix engine's opcode/index bus: answers GET_N/GET_R/READ_A/READ_X/READ_B

---
 rtl/mo_mem_responder_pkg.sv | 38 +++
 rtl/mo_mem_responder_if.sv | 48 ++++
 rtl/mo_mem_responder_mat_store.sv | 57 +++++
 rtl/mo_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mo_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mo_mem_responder_pkg
//  Purpose  : Shared constants for the matrix-engine memory responder:
//             engine opcodes, host load selectors, widths and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package mo_mem_responder_pkg;

    // Default operand/dim and result widths, and engine/host index width
    localparam int DW_DEF = 10;
    localparam int OW_DEF = 20;
    localparam int IW     = 10;

    // Engine opcodes
    localparam logic [2:0] OP_GET_N   = 3'd0;
    localparam logic [2:0] OP_GET_R   = 3'd1;
    localparam logic [2:0] OP_READ_A  = 3'd2;
    localparam logic [2:0] OP_READ_X  = 3'd3;
    localparam logic [2:0] OP_READ_B  = 3'd4;
    localparam logic [2:0] OP_WRITE_Y = 3'd5;
    localparam logic [2:0] OP_INIT    = 3'd7;

    // Host load selectors
    localparam logic [1:0] LD_DIMS = 2'd0;
    localparam logic [1:0] LD_A    = 2'd1;
    localparam logic [1:0] LD_X    = 2'd2;
    localparam logic [1:0] LD_B    = 2'd3;

    // Responder run state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mo_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mo_mem_responder_if
//  Purpose  : Engine opcode/index bus plus host load/start/readback port.
//             slave = responder side, master = engine/host side.
//  Revision : 1.0 - initial release
// ============================================================================
interface mo_mem_responder_if
    import mo_mem_responder_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
);
    // Engine side
    logic [2:0]    opcode;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [OW-1:0] out_data;
    logic          fin;
    logic [DW-1:0] in_data;
    logic          eng_rst_n;
    // Host side
    logic          ld_en;
    logic [1:0]    ld_sel;
    logic [IW-1:0] ld_i;
    logic [IW-1:0] ld_j;
    logic [DW-1:0] ld_data;
    logic          start;
    logic [IW-1:0] rd_i;
    logic [IW-1:0] rd_j;
    logic [OW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  opcode, i, j, out_data, fin,
        input  ld_en, ld_sel, ld_i, ld_j, ld_data, start, rd_i, rd_j,
        output in_data, eng_rst_n, rd_data, busy, done, err
    );

    modport master (
        output opcode, i, j, out_data, fin,
        output ld_en, ld_sel, ld_i, ld_j, ld_data, start, rd_i, rd_j,
        input  in_data, eng_rst_n, rd_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mo_mem_responder_mat_store.sv
`default_nettype none
// ============================================================================
//  Module   : mo_mat_store
//  Purpose  : ROWS x COLS register file, one synchronous write port, one
//             combinational read port, optional synchronous bulk clear.
//             Out-of-range writes are dropped, out-of-range reads return 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mo_mat_store
    import mo_mem_responder_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int W    = 10
) (
    input  wire logic          clk,
    input  wire logic          clr_i,
    input  wire logic          we_i,
    input  wire logic [IW-1:0] wr_row_i,
    input  wire logic [IW-1:0] wr_col_i,
    input  wire logic [W-1:0]  wr_data_i,
    input  wire logic [IW-1:0] rd_row_i,
    input  wire logic [IW-1:0] rd_col_i,
    output logic      [W-1:0]  rd_data_o
);
    localparam int            RAW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int            CAW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [IW-1:0] ROWS_C = IW'(ROWS);
    localparam logic [IW-1:0] COLS_C = IW'(COLS);

    logic [W-1:0] mem_q [ROWS][COLS];
    logic         wr_ok;

    assign wr_ok = we_i && (wr_row_i < ROWS_C) && (wr_col_i < COLS_C);

    // Bulk clear takes priority over the single-entry write
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            mem_q[wr_row_i[RAW-1:0]][wr_col_i[CAW-1:0]] <= wr_data_i;
        end
    end

    // Zero-latency read, zero outside the array
    always_comb begin
        rd_data_o = '0;
        if ((rd_row_i < ROWS_C) && (rd_col_i < COLS_C)) begin
            rd_data_o = mem_q[rd_row_i[RAW-1:0]][rd_col_i[CAW-1:0]];
        end
    end
endmodule
`default_nettype wire

// File: rtl/mo_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mo_mem_responder
//  Purpose  : Memory-side responder for the matrix engine. Serves dims and
//             A/X/B operands, captures Y = A*X + B row-major, holds the engine
//             in reset outside a run, detects fin/timeout, flags errors.
//  Revision : 1.0 - initial release
// ============================================================================
module mo_mem_responder
    import mo_mem_responder_pkg::*;
#(
    parameter int MAX_N   = 8,
    parameter int MAX_R   = 8,
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int TIMEOUT = 4096
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mo_mem_responder_if.slave bus
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] MAX_N_C  = IW'(MAX_N);
    localparam logic [IW-1:0] MAX_R_C  = IW'(MAX_R);

    state_t        state_q, state_d;
    logic          eng_rst_n_q;
    logic          err_q, err_d;
    logic [IW-1:0] n_q, n_d, r_q, r_d;
    logic [IW-1:0] y_row_q, y_row_d, y_col_q, y_col_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic          a_we, x_we, b_we, y_we, y_clr;
    logic [DW-1:0] a_rd, x_rd, b_rd, in_data_w;
    logic          dims_ok;

    assign dims_ok = (n_q != '0) && (n_q <= MAX_N_C) && (r_q != '0) && (r_q <= MAX_R_C);

    // State and bookkeeping registers; engine reset released only while in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            eng_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
            n_q         <= '0;
            r_q         <= '0;
            y_row_q     <= '0;
            y_col_q     <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            eng_rst_n_q <= (state_d == ST_RUN);
            err_q       <= err_d;
            n_q         <= n_d;
            r_q         <= r_d;
            y_row_q     <= y_row_d;
            y_col_q     <= y_col_d;
            cyc_q       <= cyc_d;
        end
    end

    // Next state, engine response, host loads and error detection
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        n_d       = n_q;
        r_d       = r_q;
        y_row_d   = y_row_q;
        y_col_d   = y_col_q;
        cyc_d     = cyc_q;
        a_we      = 1'b0;
        x_we      = 1'b0;
        b_we      = 1'b0;
        y_we      = 1'b0;
        y_clr     = 1'b0;
        in_data_w = '0;

        if (state_q == ST_RUN) begin
            // Host cannot touch the matrices while the engine runs
            if (bus.ld_en) err_d = 1'b1;

            case (bus.opcode)
                OP_GET_N: in_data_w = DW'(n_q);
                OP_GET_R: in_data_w = DW'(r_q);
                OP_READ_A: begin
                    if ((bus.i < n_q) && (bus.j < r_q)) in_data_w = a_rd;
                    else                                err_d     = 1'b1;
                end
                OP_READ_X: begin
                    if ((bus.i < r_q) && (bus.j < n_q)) in_data_w = x_rd;
                    else                                err_d     = 1'b1;
                end
                OP_READ_B: begin
                    if ((bus.i < n_q) && (bus.j < n_q)) in_data_w = b_rd;
                    else                                err_d     = 1'b1;
                end
                OP_WRITE_Y: begin
                    // y_row reaching N means all N*N results are already in
                    if (y_row_q < n_q) begin
                        y_we = 1'b1;
                        if (y_col_q == n_q - 1'b1) begin
                            y_col_d = '0;
                            y_row_d = y_row_q + 1'b1;
                        end else begin
                            y_col_d = y_col_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_INIT: in_data_w = '0;
                default: in_data_w = '0;
            endcase

            if (cyc_q != CYC_LAST) cyc_d = cyc_q + 1'b1;

            // fin wins over a simultaneous timeout
            if (bus.fin) begin
                state_d = ST_DONE;
                if (y_row_d != n_q) err_d = 1'b1;
            end else if (cyc_q == CYC_LAST) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end
        end else if (bus.ld_en) begin
            // A load in the same cycle as start suppresses the start
            case (bus.ld_sel)
                LD_DIMS: begin
                    n_d = bus.ld_i;
                    r_d = bus.ld_j;
                end
                LD_A: begin
                    if ((bus.ld_i < MAX_N_C) && (bus.ld_j < MAX_R_C)) a_we  = 1'b1;
                    else                                              err_d = 1'b1;
                end
                LD_X: begin
                    if ((bus.ld_i < MAX_R_C) && (bus.ld_j < MAX_N_C)) x_we  = 1'b1;
                    else                                              err_d = 1'b1;
                end
                default: begin
                    if ((bus.ld_i < MAX_N_C) && (bus.ld_j < MAX_N_C)) b_we  = 1'b1;
                    else                                              err_d = 1'b1;
                end
            endcase
        end else if (bus.start) begin
            if (dims_ok) begin
                state_d = ST_RUN;
                y_clr   = 1'b1;
                y_row_d = '0;
                y_col_d = '0;
                cyc_d   = '0;
                err_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    mo_mat_store #(.ROWS(MAX_N), .COLS(MAX_R), .W(DW)) u_a (
        .clk(clk), .clr_i(1'b0), .we_i(a_we),
        .wr_row_i(bus.ld_i), .wr_col_i(bus.ld_j), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.i), .rd_col_i(bus.j), .rd_data_o(a_rd)
    );

    mo_mat_store #(.ROWS(MAX_R), .COLS(MAX_N), .W(DW)) u_x (
        .clk(clk), .clr_i(1'b0), .we_i(x_we),
        .wr_row_i(bus.ld_i), .wr_col_i(bus.ld_j), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.i), .rd_col_i(bus.j), .rd_data_o(x_rd)
    );

    mo_mat_store #(.ROWS(MAX_N), .COLS(MAX_N), .W(DW)) u_b (
        .clk(clk), .clr_i(1'b0), .we_i(b_we),
        .wr_row_i(bus.ld_i), .wr_col_i(bus.ld_j), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.i), .rd_col_i(bus.j), .rd_data_o(b_rd)
    );

    // Y is cleared by reset and by every accepted start
    mo_mat_store #(.ROWS(MAX_N), .COLS(MAX_N), .W(OW)) u_y (
        .clk(clk), .clr_i(reset | y_clr), .we_i(y_we),
        .wr_row_i(y_row_q), .wr_col_i(y_col_q), .wr_data_i(bus.out_data),
        .rd_row_i(bus.rd_i), .rd_col_i(bus.rd_j), .rd_data_o(bus.rd_data)
    );

    assign bus.in_data   = in_data_w;
    assign bus.eng_rst_n = eng_rst_n_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
endmodule
`default_nettype wire
